y86_execute_stage: RTL and testbench
====================================

# y86_execute_stage

Registered execute stage for the Y86 pipeline with a parameterised datapath width. It selects ALU operands from the decoded instruction and computes valE. It holds the architectural condition-code register (ZF/SF/OF) and derives `cnd` for cmovXX/jXX. It sits between the decode/execute and execute/memory pipeline registers, with a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 64, datapath width in bits (≥16)
- `STEP`, WIDTH/8, stack-pointer increment used by push/pop/call/ret
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage can accept; `!out_valid || out_ready`
- `icode`, `ifun`  in  4 each  instruction code / function
- `valA`, `valB`, `valC`  in  WIDTH each  signed operands
- `dstE`  in  4  destination register for valE (4'hF = none)
- `in_stat`  in  3  status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- `cc_inhibit`  in  1  a later stage holds an exception; blocks CC update
- `out_valid`  out  1  result register valid
- `out_ready`  in  1  downstream accepts
- `out_icode`, `out_stat`, `out_dstE`  out  4/3/4  registered pass-through; `out_dstE` is conditioned
- `valE`, `out_valA`  out  WIDTH each  ALU result / valA pass-through
- `cnd`  out  1  condition result
- `cc`  out  3  current {ZF,SF,OF}

## Operation
- Accept occurs when `in_valid && in_ready`; all outputs load on accept.
- aluA:
  - valA for icode 2 and 6.
  - valC for icode 3, 4 and 5.
  - −STEP for icode 8 and A.
  - +STEP for icode 9 and B.
  - 0 otherwise.
- aluB:
  - valB for icode 4, 5, 6, 8, 9, A and B.
  - 0 otherwise.
- ALU function is `ifun` for icode 6 and add for all others.
  - 0 add: B+A.
  - 1 sub: B−A.
  - 2 and.
  - 3 xor.
  - icode 6 with ifun >3: valE=0, no CC update.
- Results are truncated to WIDTH, two's complement.
- New flags:
  - ZF = (res==0).
  - SF = res[WIDTH-1].
  - OF for add: sign(A)==sign(B) && sign(res)!=sign(A).
  - OF for sub: sign(A)!=sign(B) && sign(res)!=sign(B).
  - OF = 0 for and/xor.
- CC writes on accept only if all of: icode==6, ifun≤3, in_stat==AOK, !cc_inhibit.
- `cnd` is evaluated from the CC value before this instruction's own update, for icode 2 or 7:
  - ifun 0: 1.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: !ZF.
  - ifun 5 ge: !(SF^OF).
  - ifun 6 g: !(SF^OF)&!ZF.
  - ifun >6: 0.
  - Other icodes: cnd=1.
- `out_dstE` = 4'hF when icode==2 && !cnd; otherwise `dstE`.
- `out_stat` = in_stat. Non-AOK instructions still pass through, but never write CC.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 per cycle while `out_ready` is high.
- Output register holds stable while `out_valid && !out_ready`. `in_ready` is low in that state.
- Simultaneous drain and accept (`out_valid && out_ready && in_valid`): the new instruction loads and `out_valid` stays 1.
- Back-to-back OPq followed by jXX: the jXX uses the CC written by the OPq (written at the OPq accept edge).
- Reset values:
  - out_valid=0.
  - cc={ZF=1,SF=0,OF=0}.
  - valE=0, out_valA=0, cnd=0.
  - out_icode=1 (nop), out_stat=1, out_dstE=4'hF.
  - In-flight result is discarded.
- `rst` has priority over accept in the same cycle.

## Configuration
- `Y86_IADDQ_EN` defined:
  - icode C is accepted with aluA=valC, aluB=valB, function add.
  - CC updates under the same gating as OPq.
- `Y86_IADDQ_EN` undefined:
  - icode C is treated as an unrecognised code: valE=0, no CC update, out_dstE passes dstE unchanged.

## Test plan
- Reset, then OPq add (icode 6, ifun 0), WIDTH=64, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE=0x8000_0000_0000_0000, cc={0,1,1}, one cycle after accept.
- subq with valA=5, valB=5 -> valE=0 and cc={1,0,0}. Next cmovne (icode 2, ifun 4), dstE=3 -> cnd=0, out_dstE=F.
- pushq (icode A), valB=0x100, STEP=8 -> valE=0xF8, cc unchanged from reset {1,0,0}.
- OPq sub with cc_inhibit=1 (valA=1, valB=0) -> valE=−1 and cc stays at its prior value. Repeat with in_stat=3 -> same behaviour.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, no CC change. Release -> next instruction completes the following cycle.
- Assert rst mid-stream with out_valid=1 -> next cycle out_valid=0, cc={1,0,0}. With `Y86_IADDQ_EN`: icode C, valC=4, valB=−4 -> valE=0, ZF=1.

Source files
------------

// File: rtl/y86_execute_stage.sv
// Y86 execute stage: ALU operand select, valE, ZF/SF/OF condition codes and cnd. Optional iaddq under `Y86_IADDQ_EN`.
// Latency is 1 cycle from accept to out_valid. The output register holds while out_valid && !out_ready, and in_ready is low then.
module y86_execute_stage #(
  parameter int WIDTH = 64,
  parameter int STEP  = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic [3:0]       dstE,
  input  logic [2:0]       in_stat,
  input  logic             cc_inhibit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [2:0]       out_stat,
  output logic [3:0]       out_dstE,
  output logic [WIDTH-1:0] valE,
  output logic [WIDTH-1:0] out_valA,
  output logic             cnd,
  output logic [2:0]       cc
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] I_IADD  = 4'hC;
  localparam logic [2:0] S_AOK   = 3'd1;
  localparam logic [WIDTH-1:0] C_STEP  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] C_NSTEP = -C_STEP;

  logic             r_out_valid;
  logic [3:0]       r_icode;
  logic [2:0]       r_stat;
  logic [3:0]       r_dst;
  logic [WIDTH-1:0] r_vale;
  logic [WIDTH-1:0] r_vala;
  logic             r_cnd;
  logic [2:0]       r_cc;

  logic             w_accept;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_res;
  logic [1:0]       w_fn;
  logic             w_is_op;
  logic             w_fn_bad;
  logic             w_of;
  logic             w_cc_src;
  logic             w_cc_we;
  logic             w_cnd;
  logic             w_zf;
  logic             w_sf;
  logic             w_sof;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (icode)
      I_CMOV, I_OP:               w_alu_a = valA;
      I_IRMOV, I_RMMOV, I_MRMOV:  w_alu_a = valC;
      I_CALL, I_PUSH:             w_alu_a = C_NSTEP;
      I_RET, I_POP:               w_alu_a = C_STEP;
`ifdef Y86_IADDQ_EN
      I_IADD:                     w_alu_a = valC;
`endif
      default:                    w_alu_a = '0;
    endcase
    case (icode)
      I_RMMOV, I_MRMOV, I_OP, I_CALL, I_RET, I_PUSH, I_POP: w_alu_b = valB;
`ifdef Y86_IADDQ_EN
      I_IADD:                     w_alu_b = valB;
`endif
      default:                    w_alu_b = '0;
    endcase
  end

  assign w_is_op  = (icode == I_OP);
  assign w_fn     = w_is_op ? ifun[1:0] : 2'd0;
  assign w_fn_bad = w_is_op && (ifun[3:2] != 2'b00);

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (w_fn)
      2'd0: begin
        w_res = w_alu_b + w_alu_a;
        w_of  = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) && (w_res[WIDTH-1] != w_alu_a[WIDTH-1]);
      end
      2'd1: begin
        w_res = w_alu_b - w_alu_a;
        w_of  = (w_alu_a[WIDTH-1] != w_alu_b[WIDTH-1]) && (w_res[WIDTH-1] != w_alu_b[WIDTH-1]);
      end
      2'd2:    w_res = w_alu_b & w_alu_a;
      default: w_res = w_alu_b ^ w_alu_a;
    endcase
    if (w_fn_bad) begin
      w_res = '0;
      w_of  = 1'b0;
    end
  end

`ifdef Y86_IADDQ_EN
  assign w_cc_src = (w_is_op && !w_fn_bad) || (icode == I_IADD);
`else
  assign w_cc_src = w_is_op && !w_fn_bad;
`endif
  assign w_cc_we = w_accept && w_cc_src && (in_stat == S_AOK) && !cc_inhibit;

  // Condition uses the flags as they stand before this instruction writes them.
  assign w_zf  = r_cc[2];
  assign w_sf  = r_cc[1];
  assign w_sof = r_cc[1] ^ r_cc[0];

  always_comb begin
    w_cnd = 1'b1;
    if (icode == I_CMOV || icode == I_JXX) begin
      case (ifun)
        4'd0:    w_cnd = 1'b1;
        4'd1:    w_cnd = w_sof | w_zf;
        4'd2:    w_cnd = w_sof;
        4'd3:    w_cnd = w_zf;
        4'd4:    w_cnd = !w_zf;
        4'd5:    w_cnd = !w_sof;
        4'd6:    w_cnd = !w_sof && !w_zf;
        default: w_cnd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_icode     <= I_NOP;
      r_stat      <= S_AOK;
      r_dst       <= 4'hF;
      r_vale      <= '0;
      r_vala      <= '0;
      r_cnd       <= 1'b0;
      r_cc        <= 3'b100;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_icode     <= icode;
        r_stat      <= in_stat;
        r_dst       <= (icode == I_CMOV && !w_cnd) ? 4'hF : dstE;
        r_vale      <= w_res;
        r_vala      <= valA;
        r_cnd       <= w_cnd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_cc_we) begin
        r_cc <= {(w_res == '0), w_res[WIDTH-1], w_of};
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_icode;
  assign out_stat  = r_stat;
  assign out_dstE  = r_dst;
  assign valE      = r_vale;
  assign out_valA  = r_vala;
  assign cnd       = r_cnd;
  assign cc        = r_cc;
  wire unused_sf = w_sf;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Bench for y86_execute_stage: a hand-derived vector table, handshake/reset sequences, then random traffic against a reference model.
module tb_y86_execute_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cc_inhibit, out_valid, out_ready, cnd;
  logic [3:0]  icode, ifun, dstE, out_icode, out_dstE;
  logic [63:0] valA, valB, valC, valE, out_valA;
  logic [2:0]  in_stat, out_stat, cc;

  int checks = 0;
  int errors = 0;
  logic [2:0] mcc;

  y86_execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .in_stat(in_stat), .cc_inhibit(cc_inhibit),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_stat(out_stat), .out_dstE(out_dstE), .valE(valE), .out_valA(out_valA),
    .cnd(cnd), .cc(cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun;
    logic [63:0] a, b, c;
    logic [3:0]  dst;
    logic [2:0]  stat;
    logic        inh;
    logic [63:0] e_vale;
    logic        e_cnd;
    logic [3:0]  e_dst;
    logic [2:0]  e_cc;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [3:0] d, input logic [2:0] st, input logic inh);
    in_valid = 1'b1; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    dstE = d; in_stat = st; cc_inhibit = inh;
  endtask

  // Reference model: architectural result of one instruction; updates mcc.
  task automatic model(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [3:0] d, input logic [2:0] st, input logic inh,
                       output logic [63:0] vale, output logic cn, output logic [3:0] dout);
    logic signed [64:0] wide;
    logic zf, sf, of, setcc;
    zf = mcc[2]; sf = mcc[1]; of = mcc[0];
    cn = 1'b1;
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        0: cn = 1; 1: cn = (sf != of) || zf; 2: cn = (sf != of); 3: cn = zf;
        4: cn = !zf; 5: cn = (sf == of); 6: cn = (sf == of) && !zf;
        default: cn = 0;
      endcase
    end
    setcc = 0; of = 0; vale = 64'd0;
    case (ic)
      4'h2: vale = a;
      4'h3: vale = c;
      4'h4, 4'h5: vale = b + c;
      4'h8, 4'hA: vale = b - 64'd8;
      4'h9, 4'hB: vale = b + 64'd8;
      4'h6: begin
        setcc = (fn <= 3);
        case (fn)
          0: begin wide = $signed({b[63], b}) + $signed({a[63], a}); vale = wide[63:0]; of = wide[64] != wide[63]; end
          1: begin wide = $signed({b[63], b}) - $signed({a[63], a}); vale = wide[63:0]; of = wide[64] != wide[63]; end
          2: vale = a & b;
          3: vale = a ^ b;
          default: vale = 64'd0;
        endcase
      end
`ifdef Y86_IADDQ_EN
      4'hC: begin
        wide = $signed({b[63], b}) + $signed({c[63], c}); vale = wide[63:0]; of = wide[64] != wide[63];
        setcc = 1;
      end
`endif
      default: vale = 64'd0;
    endcase
    if (setcc && st == 3'd1 && !inh) mcc = {vale == 64'd0, vale[63], of};
    dout = (ic == 4'h2 && !cn) ? 4'hF : d;
  endtask

  task automatic add(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] c, input logic [3:0] d, input logic [2:0] st, input logic inh,
                     input logic [63:0] ev, input logic ec, input logic [3:0] ed, input logic [2:0] ecc);
    vec_t v;
    v = '{ic, fn, a, b, c, d, st, inh, ev, ec, ed, ecc};
    vecs.push_back(v);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_cc"},    64'(cc), 64'h4);
    chk({tag, "_vale"},  valE, 64'd0);
    chk({tag, "_vala"},  out_valA, 64'd0);
    chk({tag, "_cnd"},   64'(cnd), 64'd0);
    chk({tag, "_icode"}, 64'(out_icode), 64'd1);
    chk({tag, "_stat"},  64'(out_stat), 64'd1);
    chk({tag, "_dst"},   64'(out_dstE), 64'hF);
  endtask

  initial begin
    logic [63:0] ev, hold_vale;
    logic ec;
    logic [3:0] ed, ic, fn;
    logic [2:0] hold_cc, st;
    logic [63:0] a, b, c;
    logic inh;

    rst = 1; in_valid = 0; out_ready = 1; cc_inhibit = 0;
    icode = 0; ifun = 0; valA = 0; valB = 0; valC = 0; dstE = 4'hF; in_stat = 1;
    mcc = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 0;

    add(6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 5, 1, 0, 64'h8000_0000_0000_0000, 1, 5, 3'b011);
    add(6, 1, 5, 5, 0, 6, 1, 0, 0, 1, 6, 3'b100);
    add(2, 4, 64'h1234, 0, 0, 3, 1, 0, 64'h1234, 0, 4'hF, 3'b100);
    add(4'hA, 0, 0, 64'h100, 0, 4, 1, 0, 64'hF8, 1, 4, 3'b100);
    add(4'hB, 0, 0, 64'h100, 0, 4, 1, 0, 64'h108, 1, 4, 3'b100);
    add(8, 0, 0, 64'h200, 0, 4, 1, 0, 64'h1F8, 1, 4, 3'b100);
    add(6, 1, 1, 0, 0, 2, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 3'b100);
    add(6, 1, 1, 0, 0, 2, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 3'b100);
    add(3, 0, 0, 0, 64'h42, 1, 1, 0, 64'h42, 1, 1, 3'b100);
    add(5, 0, 0, 64'h20, 64'h10, 4'hF, 1, 0, 64'h30, 1, 4'hF, 3'b100);
    add(6, 2, 64'hF0, 64'h0F, 0, 0, 1, 0, 0, 1, 0, 3'b100);
    add(6, 3, 64'hFF, 64'h0F, 0, 0, 1, 0, 64'hF0, 1, 0, 3'b000);
    add(7, 2, 0, 0, 0, 4'hF, 1, 0, 0, 0, 4'hF, 3'b000);
    add(6, 7, 5, 9, 0, 1, 1, 0, 0, 1, 1, 3'b000);
    add(6, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 2, 3'b010);
    add(7, 2, 0, 0, 0, 4'hF, 1, 0, 0, 1, 4'hF, 3'b010);
    add(2, 1, 7, 0, 0, 4, 1, 0, 7, 1, 4, 3'b010);
    add(6, 1, 1, 64'h8000_0000_0000_0000, 0, 3, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 3, 3'b001);
    add(7, 6, 0, 0, 0, 4'hF, 1, 0, 0, 0, 4'hF, 3'b001);
    add(7, 4, 0, 0, 0, 4'hF, 1, 0, 0, 1, 4'hF, 3'b001);
`ifdef Y86_IADDQ_EN
    add(4'hC, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 4, 7, 1, 0, 0, 1, 7, 3'b100);
`else
    add(4'hC, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 4, 7, 1, 0, 0, 1, 7, 3'b001);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].dst, vecs[i].stat, vecs[i].inh);
      model(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].dst, vecs[i].stat, vecs[i].inh, ev, ec, ed);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_vale", i), valE, vecs[i].e_vale);
      chk($sformatf("vec%0d_cnd", i), 64'(cnd), 64'(vecs[i].e_cnd));
      chk($sformatf("vec%0d_dst", i), 64'(out_dstE), 64'(vecs[i].e_dst));
      chk($sformatf("vec%0d_cc", i), 64'(cc), 64'(vecs[i].e_cc));
      chk($sformatf("vec%0d_stat", i), 64'(out_stat), 64'(vecs[i].stat));
    end

    // Stall: output frozen, no accept, flags untouched.
    hold_vale = valE; hold_cc = cc;
    out_ready = 0;
    drive(6, 0, 1, 2, 0, 5, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_vale", valE, hold_vale);
      chk("hold_cc", 64'(cc), 64'(hold_cc));
    end
    out_ready = 1;
    model(6, 0, 1, 2, 0, 5, 1, 0, ev, ec, ed);
    @(posedge clk); #1;
    chk("release_vale", valE, 64'd3);
    chk("release_cc", 64'(cc), 64'(mcc));

    // Back-to-back subq then je: jump sees the flags just written.
    drive(6, 1, 5, 5, 0, 6, 1, 0);
    model(6, 1, 5, 5, 0, 6, 1, 0, ev, ec, ed);
    @(posedge clk); #1;
    chk("b2b_sub_cc", 64'(cc), 64'h4);
    drive(7, 3, 0, 0, 0, 4'hF, 1, 0);
    model(7, 3, 0, 0, 0, 4'hF, 1, 0, ev, ec, ed);
    @(posedge clk); #1;
    chk("b2b_je_cnd", 64'(cnd), 64'd1);
    chk("b2b_je_valid", 64'(out_valid), 64'd1);

    // Reset mid-stream wins over a pending accept.
    drive(6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 5, 1, 0);
    rst = 1;
    @(posedge clk); #1;
    check_reset("rst1");
    rst = 0; in_valid = 0; mcc = 3'b100;
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
        chk("rnd_idle_valid", 64'(out_valid), 64'd0);
      end else begin
        ic  = 4'($urandom_range(0, 12));
        fn  = 4'($urandom_range(0, 7));
        a   = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        b   = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a = b;
        c   = {$urandom, $urandom};
        st  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
        inh = ($urandom_range(0, 7) == 0);
        ed  = 4'($urandom);
        drive(ic, fn, a, b, c, ed, st, inh);
        model(ic, fn, a, b, c, ed, st, inh, ev, ec, ed);
        @(posedge clk); #1;
        chk("rnd_valid", 64'(out_valid), 64'd1);
        chk("rnd_vale", valE, ev);
        chk("rnd_cnd", 64'(cnd), 64'(ec));
        chk("rnd_dst", 64'(out_dstE), 64'(ed));
        chk("rnd_cc", 64'(cc), 64'(mcc));
        chk("rnd_icode", 64'(out_icode), 64'(ic));
        chk("rnd_vala", out_valA, a);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
